fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-side controller of the asynchronous FIFO, running entirely in the read clock domain.
//  - Brings the Gray-coded write pointer across with a synchronizer.
//  - Keeps the binary and Gray read pointers and generates the empty flag.
//  - Drives the read address and read-inhibit of the dual-port FIFO memory.
//  - Presents the popped word on a valid/ready interface.
// PARAMETERS
//  Data_width    8  width of a FIFO word
//  Address_width 3  memory address bits; depth = 2**Address_width
//  Sync_stages   2  flops in the write-pointer synchronizer (>=2)
// PORTS
//  Rclk        in   1                read-domain clock; all logic on posedge
//  Rrst        in   1                reset, asynchronous, active-high
//  Wgray_ptr   in   Address_width+1  write pointer, Gray, from the write domain (asynchronous)
//  Rgray_ptr   out  Address_width+1  read pointer, Gray, registered, to the write domain
//  Radder      out  Address_width    memory read address (registered)
//  Rmem_hold   out  1                to the memory's Rempty_flag input; 1 = memory must not read
//  Rmem_data   in   Data_width       memory Rdata (1-cycle read latency)
//  Rempty      out  1                FIFO empty as seen by the read domain (registered)
//  Rd_data     out  Data_width       popped word = Rmem_data; meaningful only while Rd_valid
//  Rd_valid    out  1                Rd_data holds an un-consumed word
//  Rd_ready    in   1                consumer accepts Rd_data this cycle
// BEHAVIOUR
//  - Reset values: Rgray_ptr=0, internal rbin=0, Radder=0, Rempty=1, Rd_valid=0, sync flops=0.
//    Rmem_hold is forced to 1 by Rempty. Reset mid-operation discards the held word; the write
//    side is reset in the same event.
//  - Sync: wq = Wgray_ptr delayed through Sync_stages flops. No other use of Wgray_ptr.
//  - fetch = !Rempty && (!Rd_valid || Rd_ready)  (combinational, from registered state).
//  - Rmem_hold = !fetch. The memory reads MEM[Radder] exactly on fetch edges, so Rmem_data
//    stays stable while stalled.
//  - Pointer update on each fetch edge:
//      rbin_n  = rbin + fetch  (Address_width+1 bits, wraps modulo 2**(Address_width+1))
//      rgray_n = (rbin_n>>1) ^ rbin_n
//    Registers: rbin<=rbin_n, Rgray_ptr<=rgray_n, Radder<=rbin_n[Address_width-1:0],
//    Rempty<=(rgray_n==wq).
//  - Rd_valid: set on a fetch edge; cleared on an edge with Rd_ready=1 and no fetch; held otherwise.
//    Simultaneous pop and fetch keeps it at 1 with the new word. Throughput: 1 word/cycle.
//  - Latency: Wgray_ptr change -> Rempty falls after Sync_stages+1 edges -> Rd_valid next edge.
//  - Empty is pessimistic: it deasserts late, never early. No read past the write pointer.
//    The extra pointer MSB separates the wrapped-full case from empty.
//  - Rd_ready while Rd_valid=0 is ignored. Rd_valid never drops without Rd_ready.
// CONFIGURATION
//  FIFO_RD_LEVEL_EN defined:
//   - Adds output Rlevel [Address_width:0], registered, reset 0.
//   - Rlevel = gray2bin(wq) - rbin_n (modulo): entries still in memory, excluding the held word.
//  FIFO_RD_LEVEL_EN undefined:
//   - No Rlevel port and no gray-to-binary logic; all other behaviour identical.
// TESTING  (defaults, Sync_stages=2)
//  1 Rrst pulse mid-stream -> immediately Rd_valid=0, Rempty=1, Rgray_ptr=0, Radder=0, Rmem_hold=1.
//  2 Wgray_ptr 0->1, Rd_ready=1 -> Rempty=0 on 3rd edge; next edge Rd_valid=1 with Rd_data=MEM[0],
//    Rgray_ptr=1, Radder=1, Rempty=1; Rd_valid=0 on the following edge.
//  3 Wgray_ptr=2 (3 words), Rd_ready=0 -> Rd_valid=1, Rd_data=MEM[0] stable >=10 cycles,
//    Rmem_hold=1, Radder=1; Rd_ready=1 -> MEM[1], MEM[2] on consecutive cycles.
//  4 16 writes/16 reads streamed -> Rgray_ptr sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0;
//    data in order, no false empty at the 8-entry wrap.
//  5 Wgray_ptr=8 (bin 8^7 wrap, 8 words), Rd_ready toggling 1010 -> exactly 8 words in order,
//    none duplicated; Rempty=1 after the last fetch.
//  6 FIFO_RD_LEVEL_EN, 5 words synced, Rd_ready=0 -> Rlevel=4 after first fetch; +1 pop -> Rlevel=3.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an asynchronous FIFO: write-pointer synchronizer, read pointers, empty flag, memory read control and valid/ready output.
// Optional FIFO_RD_LEVEL_EN adds the registered o_Rlevel occupancy output.
module fifo_read_ctrl #(
    parameter int Data_width    = 8,
    parameter int Address_width = 3,
    parameter int Sync_stages   = 2
) (
    input  logic                     i_Rclk,
    input  logic                     i_Rrst,
    input  logic [Address_width:0]   i_Wgray_ptr,
    output logic [Address_width:0]   o_Rgray_ptr,
    output logic [Address_width-1:0] o_Radder,
    output logic                     o_Rmem_hold,
    input  logic [Data_width-1:0]    i_Rmem_data,
    output logic                     o_Rempty,
    output logic [Data_width-1:0]    o_Rd_data,
    output logic                     o_Rd_valid,
    input  logic                     i_Rd_ready
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [Address_width:0]   o_Rlevel
`endif
);

    logic [Address_width:0]   r_sync [Sync_stages];
    logic [Address_width:0]   r_rbin;
    logic [Address_width:0]   r_rgray;
    logic [Address_width-1:0] r_radder;
    logic                     r_rempty;
    logic                     r_rd_valid;

    logic [Address_width:0]   w_wq;
    logic [Address_width:0]   w_rbin_n;
    logic [Address_width:0]   w_rgray_n;
    logic                     w_fetch;

    always_ff @(posedge i_Rclk or posedge i_Rrst) begin
        if (i_Rrst) begin
            for (int i = 0; i < Sync_stages; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_Wgray_ptr;
            for (int i = 1; i < Sync_stages; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_wq      = r_sync[Sync_stages-1];
    // A fetch reads memory into the output slot; only when it is empty or being drained.
    assign w_fetch   = !r_rempty && (!r_rd_valid || i_Rd_ready);
    assign w_rbin_n  = r_rbin + {{Address_width{1'b0}}, w_fetch};
    assign w_rgray_n = (w_rbin_n >> 1) ^ w_rbin_n;

    always_ff @(posedge i_Rclk or posedge i_Rrst) begin
        if (i_Rrst) begin
            r_rbin     <= '0;
            r_rgray    <= '0;
            r_radder   <= '0;
            r_rempty   <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            r_rbin   <= w_rbin_n;
            r_rgray  <= w_rgray_n;
            r_radder <= w_rbin_n[Address_width-1:0];
            r_rempty <= (w_rgray_n == w_wq);
            if (w_fetch)
                r_rd_valid <= 1'b1;
            else if (i_Rd_ready)
                r_rd_valid <= 1'b0;
        end
    end

    assign o_Rgray_ptr = r_rgray;
    assign o_Radder    = r_radder;
    assign o_Rempty    = r_rempty;
    assign o_Rd_valid  = r_rd_valid;
    assign o_Rmem_hold = !w_fetch;
    assign o_Rd_data   = i_Rmem_data;

`ifdef FIFO_RD_LEVEL_EN
    logic [Address_width:0] w_wq_bin;
    logic [Address_width:0] r_rlevel;

    always_comb begin
        w_wq_bin = '0;
        for (int i = 0; i <= Address_width; i++) w_wq_bin[i] = ^(w_wq >> i);
    end

    always_ff @(posedge i_Rclk or posedge i_Rrst) begin
        if (i_Rrst) r_rlevel <= '0;
        else        r_rlevel <= w_wq_bin - w_rbin_n;
    end

    assign o_Rlevel = r_rlevel;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: write-side/memory model, scoreboard of pushed words, vector table plus directed sequences.
module tb_fifo_read_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] wgray = '0;
    logic [3:0] rgray;
    logic [2:0] radder;
    logic       hold;
    logic [7:0] rdata = '0;
    logic       empty;
    logic [7:0] rd_data;
    logic       valid;
    logic       rd_ready = 1'b0;
`ifdef FIFO_RD_LEVEL_EN
    logic [3:0] rlevel;
`endif

    fifo_read_ctrl #(.Data_width(8), .Address_width(3), .Sync_stages(2)) dut (
        .i_Rclk     (clk),
        .i_Rrst     (rst),
        .i_Wgray_ptr(wgray),
        .o_Rgray_ptr(rgray),
        .o_Radder   (radder),
        .o_Rmem_hold(hold),
        .i_Rmem_data(rdata),
        .o_Rempty   (empty),
        .o_Rd_data  (rd_data),
        .o_Rd_valid (valid),
        .i_Rd_ready (rd_ready)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .o_Rlevel   (rlevel)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [8];
    logic [3:0] wbin = '0;
    logic [7:0] q [$];
    int total = 0;
    int bad = 0;
    int pops = 0;

    always @(posedge clk) if (!hold) rdata <= mem[radder];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Scoreboard: a word is consumed on the next edge whenever valid and ready meet.
    always @(negedge clk) begin
        if (!rst && valid && rd_ready) begin
            pops++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: got word %0h expected none", rd_data);
            end else begin
                logic [7:0] e;
                e = q.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL sb_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wbin[2:0]] = d;
        wbin = wbin + 4'd1;
        wgray = wbin ^ (wbin >> 1);
        q.push_back(d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        wbin = '0;
        wgray = '0;
        rd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_valid(input string nm, input int lim);
        int n = 0;
        while (!valid && n < lim) begin
            tick();
            n++;
        end
        chk(nm, valid, 1);
    endtask

    typedef struct {
        logic       ready;
        logic       e;
        logic       v;
        logic [3:0] g;
        logic [2:0] a;
        logic       h;
    } vec_t;

    vec_t tbl [5];
    logic [3:0] exp_g [17];
    logic [3:0] seen [$];

    initial begin
        int base;
        int n;
        int pushed;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 4'h1, 3'd1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 4'h1, 3'd1, 1'b1};
        exp_g = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_valid", valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_gray", rgray, 0);
        chk("rst_radder", radder, 0);
        chk("rst_hold", hold, 1);
        rst = 1'b0;
        tick();

        // One word, ready high: cycle-exact table
        push(8'hA5);
        for (int i = 0; i < 5; i++) begin
            rd_ready = tbl[i].ready;
            tick();
            chk($sformatf("t2_empty[%0d]", i), empty, tbl[i].e);
            chk($sformatf("t2_valid[%0d]", i), valid, tbl[i].v);
            chk($sformatf("t2_gray[%0d]", i), rgray, tbl[i].g);
            chk($sformatf("t2_radder[%0d]", i), radder, tbl[i].a);
            chk($sformatf("t2_hold[%0d]", i), hold, tbl[i].h);
            if (i == 3) chk("t2_data", rd_data, 8'hA5);
        end

        // Three words, stalled consumer
        do_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_valid("t3_wait", 20);
        for (int i = 0; i < 10; i++) begin
            chk("t3_data_stable", rd_data, 8'h11);
            chk("t3_hold", hold, 1);
            chk("t3_radder", radder, 1);
            tick();
        end
        rd_ready = 1'b1;
        tick();
        chk("t3_w1_valid", valid, 1);
        chk("t3_w1", rd_data, 8'h22);
        tick();
        chk("t3_w2_valid", valid, 1);
        chk("t3_w2", rd_data, 8'h33);
        tick();
        chk("t3_drained", valid, 0);

        // 16 words streamed across the pointer wrap
        do_reset();
        rd_ready = 1'b1;
        seen.delete();
        seen.push_back(rgray);
        base = pops;
        pushed = 0;
        n = 0;
        while ((pops - base) < 16 && n < 300) begin
            if (pushed < 16 && q.size() < 8) begin
                push(8'h40 + 8'(pushed));
                pushed++;
            end
            tick();
            if (rgray != seen[seen.size()-1]) seen.push_back(rgray);
            n++;
        end
        tick();
        tick();
        if (rgray != seen[seen.size()-1]) seen.push_back(rgray);
        chk("t4_pops", pops - base, 16);
        chk("t4_gray_len", seen.size(), 17);
        for (int i = 0; i < 17 && i < seen.size(); i++)
            chk($sformatf("t4_gray[%0d]", i), seen[i], exp_g[i]);
        chk("t4_empty", empty, 1);

        // Reset with a word held
        do_reset();
        push(8'h5A);
        push(8'h6B);
        wait_valid("t1_wait", 20);
        rst = 1'b1;
        #1;
        chk("t1_valid", valid, 0);
        chk("t1_empty", empty, 1);
        chk("t1_gray", rgray, 0);
        chk("t1_radder", radder, 0);
        chk("t1_hold", hold, 1);
        q.delete();
        wbin = '0;
        wgray = '0;
        tick();
        rst = 1'b0;
        tick();

        // Eight words sitting across the address wrap, toggling ready
        rd_ready = 1'b1;
        base = pops;
        for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
        n = 0;
        while ((pops - base) < 7 && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("t5_pre_pops", pops - base, 7);
        chk("t5_pre_empty", empty, 1);
        base = pops;
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        chk("t5_wgray", wgray, 4'h8);
        for (int c = 0; c < 60; c++) begin
            rd_ready = (c % 2 == 0);
            tick();
        end
        rd_ready = 1'b1;
        tick();
        tick();
        chk("t5_pops", pops - base, 8);
        chk("t5_q_left", q.size(), 0);
        chk("t5_empty", empty, 1);
        chk("t5_valid", valid, 0);
        chk("t5_gray", rgray, 4'h8);

`ifdef FIFO_RD_LEVEL_EN
        do_reset();
        chk("t6_rst_level", rlevel, 0);
        for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
        wait_valid("t6_wait", 20);
        tick();
        chk("t6_level4", rlevel, 4);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tick();
        chk("t6_level3", rlevel, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
